// File: rtl/disp_pkg.sv
// Shared types and constants for the board display sequencer.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW_HI = 2'd1,
    SHOW_LO = 2'd2,
    BLANK   = 2'd3
  } state_t;

  localparam int DWELL_CYCLES_DEFAULT = 50_000_000;

  // Index width for a given requester count, never narrower than one bit.
  function automatic int src_w(input int num_src);
    return (num_src > 1) ? $clog2(num_src) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester after last_idx,
// wrapping, so last_idx itself is chosen only when it is the sole valid one.
module rr_pick
  import disp_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2
) (
  input  logic [NUM_SRC-1:0] valid,
  input  logic [SRC_W-1:0]   last_idx,
  output logic [SRC_W-1:0]   next_idx,
  output logic               any_valid
);

  logic [SRC_W-1:0]   cand_idx [NUM_SRC];
  logic [NUM_SRC-1:0] cand_hit;

  // Candidate gi sits at offset gi+1 from the last index shown.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_cand
      assign cand_idx[gi] = SRC_W'((int'(last_idx) + gi + 1) % NUM_SRC);
      assign cand_hit[gi] = valid[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    next_idx  = last_idx;
    any_valid = |valid;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (cand_hit[i]) begin
        next_idx = cand_idx[i];
      end
    end
  end

endmodule

// File: rtl/display_sequencer.sv
// Time-shares a 16-bit display among NUM_SRC snapshotted 32-bit words, upper
// half then lower half. Optional DISPLAY_BLANK_GAP_EN inserts a blank gap.
module display_sequencer
  import disp_pkg::*;
#(
  parameter int N            = 32,
  parameter int NUM_SRC      = 4,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEFAULT,
  localparam int SRC_W       = src_w(NUM_SRC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC*N-1:0] src_data,
  input  logic [NUM_SRC-1:0]   src_valid,
  input  logic                 mode_auto,
  input  logic                 step_btn,
  input  logic [SRC_W-1:0]     sel_manual,
  output logic [N/2-1:0]       disp_out,
  output logic [SRC_W-1:0]     disp_src,
  output logic                 disp_half,
  output logic                 frame_done
);

  localparam int H     = N / 2;
  localparam int CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
`ifdef DISPLAY_BLANK_GAP_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(DWELL_CYCLES / 4 - 1);
`endif

  state_t           state_reg, state_next;
  logic [N-1:0]     snap_reg, snap_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             step_d_reg;
  logic [H-1:0]     disp_out_reg, disp_out_next;
  logic [SRC_W-1:0] disp_src_reg, src_next;
  logic             disp_half_reg, frame_done_reg, frame_next;

  logic [SRC_W-1:0] rr_idx;
  logic             rr_any;
  logic             step_rise, cnt_term, advance, load_snap;

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .valid     (src_valid),
    .last_idx  (disp_src_reg),
    .next_idx  (rr_idx),
    .any_valid (rr_any)
  );

  assign step_rise = step_btn & ~step_d_reg;
`ifdef DISPLAY_BLANK_GAP_EN
  assign cnt_term  = (state_reg == BLANK) ? (cnt_reg == BLANK_LAST) : (cnt_reg == DWELL_LAST);
`else
  assign cnt_term  = (cnt_reg == DWELL_LAST);
`endif
  // Only the advance source of the current mode counts; the other is ignored.
  assign advance   = mode_auto ? cnt_term : step_rise;

  always_comb begin
    state_next = state_reg;
    src_next   = disp_src_reg;
    load_snap  = 1'b0;
    frame_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (mode_auto) begin
          if (rr_any) begin
            src_next   = rr_idx;
            load_snap  = 1'b1;
            state_next = SHOW_HI;
          end
        end else if (step_rise) begin
          src_next   = sel_manual;
          load_snap  = 1'b1;
          state_next = SHOW_HI;
        end
      end
      SHOW_HI: begin
        if (advance) state_next = SHOW_LO;
      end
      SHOW_LO: begin
        if (advance) begin
          frame_next = 1'b1;
          if (mode_auto && !rr_any) begin
            state_next = IDLE;
          end else begin
            src_next = mode_auto ? rr_idx : sel_manual;
`ifdef DISPLAY_BLANK_GAP_EN
            state_next = BLANK;
`else
            load_snap  = 1'b1;
            state_next = SHOW_HI;
`endif
          end
        end
      end
`ifdef DISPLAY_BLANK_GAP_EN
      BLANK: begin
        // The upcoming source was chosen on LO exit; its word is captured here.
        if (advance) begin
          load_snap  = 1'b1;
          state_next = SHOW_HI;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    snap_next = snap_reg;
    if (load_snap) begin
      snap_next = src_data[int'(src_next)*N +: N];
    end
    if (!mode_auto || state_reg == IDLE || cnt_term) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  // Outputs are registered from the next state so they align with it.
  always_comb begin
    disp_out_next = '0;
    case (state_next)
      SHOW_HI: disp_out_next = snap_next[N-1:H];
      SHOW_LO: disp_out_next = snap_next[H-1:0];
      default: disp_out_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      snap_reg       <= '0;
      cnt_reg        <= '0;
      step_d_reg     <= 1'b0;
      disp_out_reg   <= '0;
      disp_src_reg   <= '0;
      disp_half_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      snap_reg       <= snap_next;
      cnt_reg        <= cnt_next;
      step_d_reg     <= step_btn;
      disp_out_reg   <= disp_out_next;
      disp_src_reg   <= src_next;
      disp_half_reg  <= (state_next == SHOW_HI);
      frame_done_reg <= frame_next;
    end
  end

  assign disp_out   = disp_out_reg;
  assign disp_src   = disp_src_reg;
  assign disp_half  = disp_half_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer with NUM_SRC=4, DWELL_CYCLES=4.
`timescale 1ns/1ps
module tb_display_sequencer;

  localparam int N       = 32;
  localparam int NUM_SRC = 4;
  localparam int DWELL   = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NUM_SRC*N-1:0] src_data;
  logic [NUM_SRC-1:0]   src_valid;
  logic                 mode_auto;
  logic                 step_btn;
  logic [1:0]           sel_manual;
  logic [N/2-1:0]       disp_out;
  logic [1:0]           disp_src;
  logic                 disp_half;
  logic                 frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  display_sequencer #(
    .N            (N),
    .NUM_SRC      (NUM_SRC),
    .DWELL_CYCLES (DWELL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .mode_auto  (mode_auto),
    .step_btn   (step_btn),
    .sel_manual (sel_manual),
    .disp_out   (disp_out),
    .disp_src   (disp_src),
    .disp_half  (disp_half),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_word(input int idx, input logic [31:0] w);
    src_data[idx*N +: N] = w;
  endtask

  // Called on the first sample after a LO half expires with a next frame due.
  task automatic frame_edge(input logic [1:0] up_src);
    chk("frame_done_lo_exit", 32'(frame_done), 32'd1);
    chk("upcoming_src", 32'(disp_src), 32'(up_src));
`ifdef DISPLAY_BLANK_GAP_EN
    chk("blank_out", 32'(disp_out), 32'd0);
    chk("blank_half", 32'(disp_half), 32'd0);
    @(negedge clk);
`endif
  endtask

  initial begin
    rst_n      = 1'b0;
    src_data   = '0;
    src_valid  = '0;
    mode_auto  = 1'b1;
    step_btn   = 1'b0;
    sel_manual = 2'd0;
    wait_cyc(2);
    chk("rst_out", 32'(disp_out), 32'd0);
    chk("rst_src", 32'(disp_src), 32'd0);
    chk("rst_half", 32'(disp_half), 32'd0);
    chk("rst_frame", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);
    chk("idle_no_valid", 32'(disp_out), 32'd0);

    // Auto mode, single source
    set_word(0, 32'hDEAD_BEEF);
    src_valid = 4'b0001;
    @(negedge clk);
    for (int i = 0; i < DWELL; i++) begin
      chk("single_hi", 32'(disp_out), 32'hDEAD);
      chk("single_hi_half", 32'(disp_half), 32'd1);
      @(negedge clk);
    end
    for (int i = 0; i < DWELL; i++) begin
      chk("single_lo", 32'(disp_out), 32'hBEEF);
      chk("single_lo_frame", 32'(frame_done), 32'd0);
      @(negedge clk);
    end
    frame_edge(2'd0);
    chk("single_reshow", 32'(disp_out), 32'hDEAD);
    @(negedge clk);
    chk("frame_done_one_cycle", 32'(frame_done), 32'd0);

    // Asynchronous reset during SHOW_LO
    wait_cyc(3);
    chk("pre_reset_lo", 32'(disp_out), 32'hBEEF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(disp_out), 32'd0);
    chk("async_rst_src", 32'(disp_src), 32'd0);
    chk("async_rst_half", 32'(disp_half), 32'd0);
    @(negedge clk);
    src_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(2);
    chk("post_rst_idle_out", 32'(disp_out), 32'd0);
    chk("post_rst_idle_half", 32'(disp_half), 32'd0);

    // Round-robin wrap plus snapshot coherency
    set_word(1, 32'h1234_5678);
    set_word(3, 32'h3333_4444);
    src_valid = 4'b1010;
    @(negedge clk);
    chk("rr_first_src", 32'(disp_src), 32'd1);
    chk("rr_first_hi", 32'(disp_out), 32'h1234);
    set_word(1, 32'hAAAA_BBBB);
    wait_cyc(4);
    chk("coherent_lo", 32'(disp_out), 32'h5678);
    wait_cyc(4);
    frame_edge(2'd3);
    chk("rr_src3_hi", 32'(disp_out), 32'h3333);
    wait_cyc(4);
    chk("rr_src3_lo", 32'(disp_out), 32'h4444);
    wait_cyc(4);
    frame_edge(2'd1);
    chk("rr_wrap_hi", 32'(disp_out), 32'hAAAA);
    wait_cyc(4);
    chk("rr_wrap_lo", 32'(disp_out), 32'hBBBB);
    wait_cyc(4);
    frame_edge(2'd3);
    chk("rr_src3_again", 32'(disp_out), 32'h3333);
    src_valid = 4'b0000;
    wait_cyc(4);
    chk("drop_valid_lo", 32'(disp_out), 32'h4444);
    wait_cyc(4);
    chk("drop_idle_out", 32'(disp_out), 32'd0);
    chk("drop_idle_half", 32'(disp_half), 32'd0);
    chk("drop_idle_frame", 32'(frame_done), 32'd1);
    chk("drop_idle_src", 32'(disp_src), 32'd3);
    @(negedge clk);
    chk("idle_stays", 32'(disp_out), 32'd0);

    // Manual stepping; valid bits are ignored
    set_word(2, 32'hCAFE_F00D);
    mode_auto  = 1'b0;
    sel_manual = 2'd2;
    wait_cyc(2);
    chk("manual_wait", 32'(disp_out), 32'd0);
    step_btn = 1'b1;
    @(negedge clk);
    chk("manual_hi", 32'(disp_out), 32'hCAFE);
    chk("manual_src", 32'(disp_src), 32'd2);
    wait_cyc(9);
    chk("manual_held_once", 32'(disp_out), 32'hCAFE);
    chk("manual_held_half", 32'(disp_half), 32'd1);
    step_btn = 1'b0;
    @(negedge clk);
    step_btn = 1'b1;
    @(negedge clk);
    chk("manual_lo", 32'(disp_out), 32'hF00D);
    chk("manual_lo_frame", 32'(frame_done), 32'd0);
    step_btn = 1'b0;
    @(negedge clk);
    step_btn = 1'b1;
    @(negedge clk);
    chk("manual_frame_done", 32'(frame_done), 32'd1);
    chk("manual_next_src", 32'(disp_src), 32'd2);
`ifdef DISPLAY_BLANK_GAP_EN
    chk("manual_blank_out", 32'(disp_out), 32'd0);
    step_btn = 1'b0;
    @(negedge clk);
    step_btn = 1'b1;
    @(negedge clk);
`endif
    chk("manual_hi_again", 32'(disp_out), 32'hCAFE);
    chk("manual_hi_half", 32'(disp_half), 32'd1);

    // Switch to auto mid-frame: current half holds a full dwell, then RR from 2
    step_btn  = 1'b0;
    mode_auto = 1'b1;
    src_valid = 4'b1001;
    wait_cyc(3);
    chk("switch_hi_held", 32'(disp_out), 32'hCAFE);
    @(negedge clk);
    chk("switch_lo", 32'(disp_out), 32'hF00D);
    wait_cyc(4);
    frame_edge(2'd3);
    chk("switch_rr_src3", 32'(disp_out), 32'h3333);
    wait_cyc(4);
    chk("switch_rr_lo3", 32'(disp_out), 32'h4444);
    wait_cyc(4);
    frame_edge(2'd0);
    chk("switch_rr_wrap0", 32'(disp_out), 32'hDEAD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_sequencer.md
Name: display_sequencer

Overview:
Schedules the shared 16-bit board display among up to NUM_SRC 32-bit requesters (register readout, PC, ALU result, memory word).
- Each selected source word is snapshotted, then shown as upper half, then lower half.
- Each half is held for a programmable dwell time.
- Sources are picked round-robin among valid requesters (auto mode) or by switches plus a step button (manual mode).
- Sits between the processor datapath debug taps and the LED/seven-segment driver.

Parameters:
N, 32, source word width; must be even; display width is N/2.
NUM_SRC, 4, number of requesters, 2..8.
DWELL_CYCLES, 50_000_000, clk cycles each half is held in auto mode; must be >= 4.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
src_data  in  NUM_SRC*N  packed source words; source i occupies bits [i*N +: N]
src_valid  in  NUM_SRC  requester i has a word to show
mode_auto  in  1  1 = timed round-robin, 0 = manual step
step_btn  in  1  manual advance, level input, already debounced; block detects the rising edge
sel_manual  in  clog2(NUM_SRC)  source index used in manual mode
disp_out  out  N/2  half-word driven to the display
disp_src  out  clog2(NUM_SRC)  index of the source being shown
disp_half  out  1  1 = upper half, 0 = lower half
frame_done  out  1  one-cycle pulse when a lower half finishes

Behaviour:
- Reset (async assert, sync release): state IDLE; disp_out=0, disp_src=0, disp_half=0, frame_done=0; snapshot, dwell counter and step edge register all cleared.
- States: IDLE, SHOW_HI, SHOW_LO (plus BLANK with the optional feature). All outputs are registered.
- IDLE, auto mode:
  - If any src_valid bit is set, pick the first valid index after disp_src (wrapping).
  - On the next edge: snapshot src_data of that index, set disp_src, go to SHOW_HI.
- IDLE, manual mode: a step edge snapshots source sel_manual (valid bit ignored) and goes to SHOW_HI.
- SHOW_HI: disp_out = snapshot[N-1:N/2], disp_half=1.
- SHOW_LO: disp_out = snapshot[N/2-1:0], disp_half=0.
- Coherency: both halves always come from the same snapshot. Changes on src_data mid-frame are not shown until the next frame.
- Auto advance:
  - The dwell counter counts 0..DWELL_CYCLES-1; the terminal count advances the state and clears the counter.
  - HI lasts exactly DWELL_CYCLES cycles, then goes to LO.
  - At the end of LO: frame_done pulses and the round-robin picks the next valid source after the current one.
  - If the current source is the only valid one, it is re-snapshotted and reshown.
  - If none are valid, go to IDLE with disp_out=0.
- Manual advance:
  - Each step edge advances HI->LO, or LO->HI of source sel_manual (new snapshot, frame_done pulse).
  - The counter is held at 0.
- Mode change mid-frame: the counter is cleared. The current half stays until the next advance event of the new mode.
- A source's src_valid dropping while it is displayed does not abort the frame. It only affects the next pick.
- Round-robin: the search starts at disp_src+1 modulo NUM_SRC, lowest offset wins, and the result is independent of absolute index priority.
- Step edge and dwell terminal count in the same cycle: the mode in effect selects which one counts; the other is ignored.

Optional Feature:
- Macro: DISPLAY_BLANK_GAP_EN.
- Defined:
  - After SHOW_LO, enter BLANK for DWELL_CYCLES/4 cycles (auto) or until the next step edge (manual), then go to SHOW_HI.
  - In BLANK: disp_out=0, disp_half=0, disp_src = upcoming source.
  - frame_done pulses on LO exit.
- Undefined: there is no BLANK state and LO goes directly to the next HI.

Decomposition:
- Package disp_pkg holds:
  - the state enum (IDLE, SHOW_HI, SHOW_LO, BLANK);
  - the default DWELL_CYCLES;
  - the width helper SRC_W = clog2(NUM_SRC).
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: valid vector and last index.
  - Outputs: next index and any_valid.
- The FSM, dwell counter, step edge detect and snapshot stay in display_sequencer.

Test Plan:
All scenarios use NUM_SRC=4 and DWELL_CYCLES=4.
- Reset mid-operation: assert rst_n=0 during SHOW_LO -> outputs go to 0 immediately without waiting for clk; after release the block returns to IDLE.
- Auto, single source: src_valid=4'b0001, word0=32'hDEAD_BEEF -> disp_out=16'hDEAD for 4 cycles, then 16'hBEEF for 4 cycles, frame_done pulses, then DEAD again.
- Round-robin wrap: src_valid=4'b1010 with the last source shown being 3 -> next frames show 1, 3, 1; src_valid cleared mid-frame of 3 -> frame completes, then IDLE with disp_out=0.
- Snapshot coherency: change word1 from 32'h1234_5678 to 32'hAAAA_BBBB during SHOW_HI -> lower half shows 16'h5678.
- Manual: mode_auto=0, sel_manual=2, word2=32'hCAFE_F00D, three step edges -> CAFE, F00D (frame_done pulses), CAFE; step held high for 10 cycles advances once only.
- With DISPLAY_BLANK_GAP_EN defined in auto mode: after LO, disp_out=0 for exactly 1 cycle, then HI of the next source.
